div_ctrl: RTL

Sequencing controller for the multi-cycle integer divider that serves DIV/DIVU in the E stage of the dual-issue pipeline. It accepts a divide request from the master E-slot, runs a radix-2 restoring iteration over WIDTH cycles, and applies signed fix-up. It drives the E_div_stall signal consumed by the hazard unit, and holds the HI/LO result until the pipeline advances. An exception or branch flush cancels it at any point.

---
 rtl/div_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequencing controller for the multi-cycle radix-2 restoring divider
// Holds the E stage while dividing and keeps HI/LO until the instruction leaves E.
module div_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             E_div_req,
   input  logic             E_div_signed,
   input  logic [WIDTH-1:0] E_src_a,
   input  logic [WIDTH-1:0] E_src_b,
   input  logic             E_advance,
   input  logic             cancel,
   output logic             E_div_stall,
   output logic             div_valid,
   output logic [WIDTH-1:0] div_hi,
   output logic [WIDTH-1:0] div_lo
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic             neg_q;
   logic             neg_r;

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // rem < dvsr always holds, so one extra bit is enough for the shifted remainder.
   always_comb begin
      abs_a   = (E_div_signed && E_src_a[WIDTH-1]) ? -E_src_a : E_src_a;
      abs_b   = (E_div_signed && E_src_b[WIDTH-1]) ? -E_src_b : E_src_b;
      rem_sh  = {rem, quo[WIDTH-1]};
      trial   = rem_sh - {1'b0, dvsr};
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         rem_nxt = trial[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b1};
      end
   end

   assign E_div_stall = E_div_req & ~cancel & ((state == IDLE) | (state == BUSY));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         div_valid <= 1'b0;
         div_hi    <= '0;
         div_lo    <= '0;
      end else if (cancel) begin
         state     <= IDLE;
         div_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (E_div_req) begin
                  dvsr  <= abs_b;
                  quo   <= abs_a;
                  rem   <= '0;
                  neg_q <= E_div_signed & (E_src_a[WIDTH-1] ^ E_src_b[WIDTH-1]);
                  neg_r <= E_div_signed & E_src_a[WIDTH-1];
                  if (E_src_b == '0) begin
                     state     <= DONE;
                     div_valid <= 1'b1;
                     div_lo    <= '1;
                     div_hi    <= E_src_a;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_W'(WIDTH);
                  end
               end
            end
            BUSY: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state     <= DONE;
                  div_valid <= 1'b1;
                  div_lo    <= neg_q ? -quo_nxt : quo_nxt;
                  div_hi    <= neg_r ? -rem_nxt : rem_nxt;
               end
            end
            DONE: begin
               if (E_advance) begin
                  state     <= IDLE;
                  div_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
